// File: rtl/tristate_buffer_pkg.sv
// tristate_buffer_pkg
//   Shared constants for the bus-driver slice.
//   CPU_BUS_W : project-wide VeriRISC data-bus width. Drivers take their
//               default WIDTH from it, so a bus-width change happens in one place.
package tristate_buffer_pkg;

  localparam int CPU_BUS_W = 8;

endpackage

// File: rtl/tristate_buffer_if.sv
// tristate_buffer_if
//   Control-side bundle between a data source and its bus driver.
//   data_en      : drive enable, active-high (source -> driver)
//   data_in      : WIDTH-bit value to place on the bus (source -> driver)
//   drive_active : driver is currently driving the bus (driver -> source)
//   The resolved bus net itself is a plain tri port on the driver, so it can
//   be wired directly onto the shared net alongside other drivers.
interface tristate_buffer_if
  import tristate_buffer_pkg::*;
#(
  parameter int WIDTH = CPU_BUS_W
);

  logic             data_en;
  logic [WIDTH-1:0] data_in;
  logic             drive_active;

  modport master (output data_en, output data_in, input drive_active);
  modport slave  (input data_en, input data_in, output drive_active);

endinterface

// File: rtl/tristate_buffer_reg.sv
// tristate_buffer_reg
//   WIDTH+1-bit capture register for the registered drive path.
//   clk     : rising-edge clock
//   rst_n   : asynchronous, active-low reset; clears enable and data at once
//   data_en : enable to capture
//   data_in : data to capture
//   en_q    : captured enable
//   data_q  : captured data
module tristate_buffer_reg
  import tristate_buffer_pkg::*;
#(
  parameter int WIDTH = CPU_BUS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_en,
  input  logic [WIDTH-1:0] data_in,
  output logic             en_q,
  output logic [WIDTH-1:0] data_q
);

  logic             en_d;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    en_d   = data_en;
    data_d = data_in;
  end

  // Enable and data share one reset so the driver output can only fall to Z
  // during reset, never pass through a driven-X state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      data_q <= '0;
    end else begin
      en_q   <= en_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/tristate_buffer.sv
// tristate_buffer
//   N-bit tri-state driver onto the shared VeriRISC data bus.
//   Parameters:
//     WIDTH      : bus width, 1..64 (default from CPU_BUS_W)
//     REGISTERED : 0 = combinational drive, 1 = enable/data registered on clk
//   Ports:
//     clk      : rising-edge clock (registered mode only)
//     rst_n    : asynchronous active-low reset (registered mode only)
//     bus      : slave side of tristate_buffer_if (data_en, data_in, drive_active)
//     data_out : bus drive, either the driven value or all-Z
//   Bus contention between several drivers is not resolved here.
module tristate_buffer
  import tristate_buffer_pkg::*;
#(
  parameter int WIDTH      = CPU_BUS_W,
  parameter int REGISTERED = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  tristate_buffer_if.slave    bus,
  output tri    [WIDTH-1:0]   data_out
);

  logic             drv_en;
  logic [WIDTH-1:0] drv_data;

  generate
    if (REGISTERED != 0) begin : g_reg
      tristate_buffer_reg #(
        .WIDTH (WIDTH)
      ) u_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_en (bus.data_en),
        .data_in (bus.data_in),
        .en_q    (drv_en),
        .data_q  (drv_data)
      );
    end else begin : g_comb
      // clk and rst_n have no function here; they may be left floating.
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst_n};
      assign drv_en      = bus.data_en;
      assign drv_data    = bus.data_in;
    end
  endgenerate

  // An X/Z enable resolves to all-X through the conditional operator; that is
  // deliberately left visible rather than masked.
  assign data_out         = drv_en ? drv_data : {WIDTH{1'bz}};
  assign bus.drive_active = drv_en;

endmodule

// File: tb/tb_tristate_buffer.sv
// tb_tristate_buffer
//   Checks combinational and registered tristate_buffer instances against a
//   behavioural model. Each mode has two instances: one on a pull-up net and
//   one on a pull-down net. A released bus reads all-ones on the first and
//   all-zeros on the second, while a driven bus reads the driven value on both,
//   so release is distinguished from driving any particular value.
`timescale 1ns/1ps
module tb_tristate_buffer;
  localparam int W = 8;
  localparam logic [W-1:0] REL_UP = '1;
  localparam logic [W-1:0] REL_DN = '0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] din = '0;

  // Clock and reset pins of the combinational instances are left floating.
  wire float_clk;
  wire float_rst;
  assign float_clk = 1'bz;
  assign float_rst = 1'bz;

  tri1 [W-1:0] bus_c_up;
  tri0 [W-1:0] bus_c_dn;
  tri1 [W-1:0] bus_r_up;
  tri0 [W-1:0] bus_r_dn;

  tristate_buffer_if #(.WIDTH(W)) if_c_up ();
  tristate_buffer_if #(.WIDTH(W)) if_c_dn ();
  tristate_buffer_if #(.WIDTH(W)) if_r_up ();
  tristate_buffer_if #(.WIDTH(W)) if_r_dn ();

  assign if_c_up.data_en = en;  assign if_c_up.data_in = din;
  assign if_c_dn.data_en = en;  assign if_c_dn.data_in = din;
  assign if_r_up.data_en = en;  assign if_r_up.data_in = din;
  assign if_r_dn.data_en = en;  assign if_r_dn.data_in = din;

  tristate_buffer #(.WIDTH(W), .REGISTERED(0)) u_c_up (
    .clk(float_clk), .rst_n(float_rst), .bus(if_c_up.slave), .data_out(bus_c_up));
  tristate_buffer #(.WIDTH(W), .REGISTERED(0)) u_c_dn (
    .clk(float_clk), .rst_n(float_rst), .bus(if_c_dn.slave), .data_out(bus_c_dn));
  tristate_buffer #(.WIDTH(W), .REGISTERED(1)) u_r_up (
    .clk(clk), .rst_n(rst_n), .bus(if_r_up.slave), .data_out(bus_r_up));
  tristate_buffer #(.WIDTH(W), .REGISTERED(1)) u_r_dn (
    .clk(clk), .rst_n(rst_n), .bus(if_r_dn.slave), .data_out(bus_r_dn));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Bus state expected on both pull nets plus drive_active.
  task automatic check_comb(input string tag, input bit exp_drive, input logic [W-1:0] exp_data);
    check_val({tag, "/c_up"}, 64'(bus_c_up), 64'(exp_drive ? exp_data : REL_UP));
    check_val({tag, "/c_dn"}, 64'(bus_c_dn), 64'(exp_drive ? exp_data : REL_DN));
    check_val({tag, "/c_act"}, 64'(if_c_up.drive_active), 64'(exp_drive));
  endtask

  task automatic check_reg(input string tag, input bit exp_drive, input logic [W-1:0] exp_data);
    check_val({tag, "/r_up"}, 64'(bus_r_up), 64'(exp_drive ? exp_data : REL_UP));
    check_val({tag, "/r_dn"}, 64'(bus_r_dn), 64'(exp_drive ? exp_data : REL_DN));
    check_val({tag, "/r_act"}, 64'(if_r_dn.drive_active), 64'(exp_drive));
  endtask

  // Registered-mode model: what the bus shows is the last (enable, data)
  // accepted at a clock edge while out of reset; any reset forgets it.
  bit           m_drive = 1'b0;
  logic [W-1:0] m_data  = '0;

  initial begin
    logic [W-1:0] sweep [3];
    sweep[0] = 8'h00; sweep[1] = 8'hFF; sweep[2] = 8'hA5;

    // Combinational mode, directed.
    en = 1'b1; din = 8'b0000_1001; #1;
    check_comb("comb_en", 1'b1, 8'b0000_1001);
    en = 1'b0; #1;
    check_comb("comb_dis", 1'b0, '0);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = sweep[i]; #1;
      check_comb("comb_sweep", 1'b1, sweep[i]);
    end

    // Registered mode: reset state, then release with enable already high.
    rst_n = 1'b0; en = 1'b0; din = '0;
    @(negedge clk); #1;
    check_reg("reg_rst", 1'b0, '0);
    rst_n = 1'b1; en = 1'b1; din = 8'h3C; #1;
    check_reg("reg_pre_edge", 1'b0, '0);
    @(posedge clk); #1;
    check_reg("reg_first", 1'b1, 8'h3C);

    // Reset asserted mid-drive releases before the next edge.
    #2 rst_n = 1'b0; #1;
    check_reg("reg_async_rst", 1'b0, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_reg("reg_redrive", 1'b1, 8'h3C);

    // Disable takes the same one-clock latency as enable.
    @(negedge clk); en = 1'b0; #1;
    check_reg("reg_dis_hold", 1'b1, 8'h3C);
    @(posedge clk); #1;
    check_reg("reg_dis_edge", 1'b0, '0);
    m_drive = 1'b0;

    // Randomised: both modes share the same inputs.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 9) != 0);
      en    = $urandom_range(0, 1);
      din   = W'($urandom);
      if (!rst_n) m_drive = 1'b0;
      #1;
      check_comb("rnd_comb", en, din);
      check_reg("rnd_reg_mid", m_drive, m_data);
      @(posedge clk);
      if (rst_n) begin
        m_drive = en;
        m_data  = din;
      end
      #1;
      check_reg("rnd_reg_edge", m_drive, m_data);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
